multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV64 subset core: R-type, addi-class I-type, ld, sd and beq. It sequences one shared ALU and one shared instruction/data memory across FETCH/DECODE/EXEC/MEM/WB cycles. It drives the datapath selects, including the immediate path fed by imm_gen, and stalls on a variable-latency memory handshake. It also keeps a retired-instruction counter.

---
 rtl/ctrl_pkg.sv | 34 +++
 rtl/instret_counter.sv | 26 ++
 rtl/multicycle_ctrl.sv | 151 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64 subset controller: opcodes,
// FSM state encoding and the datapath select codes it drives.
package ctrl_pkg;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC_R    = 4'd2,
    ST_EXEC_I    = 4'd3,
    ST_EXEC_ADDR = 4'd4,
    ST_MEM_RD    = 4'd5,
    ST_MEM_WR    = 4'd6,
    ST_WB_ALU    = 4'd7,
    ST_WB_MEM    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_ILLEGAL   = 4'd10
  } state_t;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_IFUNCT = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter: synchronous clear, increment enable,
// wraps modulo 2^CNT_W.
module instret_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// ALU and memory, stalling on mem_ready, and counts retired instructions.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int OPC_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] w_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output and the next state get a default before the case so
  // no path through the block leaves a value unassigned (no latches).
  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_OP_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    // Reset forces every control output low, not just the next state.
    if (!reset) begin
      unique case (r_state)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
          if (mem_ready) w_next = ST_DECODE;
        end
        ST_DECODE: begin
          alu_src_b = SRCB_IMM;
          if (opcode == OPC_W'(OPC_R))        w_next = ST_EXEC_R;
          else if (opcode == OPC_W'(OPC_I))   w_next = ST_EXEC_I;
          else if (opcode == OPC_W'(OPC_LD) ||
                   opcode == OPC_W'(OPC_SD))  w_next = ST_EXEC_ADDR;
          else if (opcode == OPC_W'(OPC_BEQ)) w_next = ST_BRANCH;
          else                                w_next = ST_ILLEGAL;
        end
        ST_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_RFUNCT;
          w_next    = ST_WB_ALU;
        end
        ST_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_OP_IFUNCT;
          w_next    = ST_WB_ALU;
        end
        ST_EXEC_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          w_next    = (opcode == OPC_W'(OPC_LD)) ? ST_MEM_RD : ST_MEM_WR;
        end
        ST_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) w_next = ST_WB_MEM;
        end
        ST_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
          end
        end
        ST_WB_ALU: begin
          reg_write = 1'b1;
          w_next    = ST_FETCH;
          w_retire  = 1'b1;
        end
        ST_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          w_next     = ST_FETCH;
          w_retire   = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_SUB;
          pc_src    = 1'b1;
          pc_en     = zero;
          w_next    = ST_FETCH;
          w_retire  = 1'b1;
        end
        ST_ILLEGAL: begin
          // PC was already advanced in FETCH, so just resume there.
          illegal = 1'b1;
          w_next  = ST_FETCH;
        end
        default: w_next = ST_FETCH;
      endcase
    end
  end

  instret_counter #(
    .CNT_W (CNT_W)
  ) u_instret (
    .clk     (clk),
    .i_clr   (reset),
    .i_inc   (w_retire),
    .o_count (w_count)
  );

  assign state   = reset ? ST_FETCH : r_state;
  assign instret = reset ? '0 : w_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios followed by
// random instruction streams compared cycle by cycle with a behavioural model.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_write;
  logic        pc_en;
  logic        pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic        mem_to_reg;
  logic        illegal;
  logic [3:0]  state;
  logic [63:0] instret;

  int          n_checks;
  int          n_errors;
  logic [63:0] model_instret;

  multicycle_ctrl #(
    .CNT_W (64),
    .OPC_W (7)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .state      (state),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [13:0] pack_ctrl(
      input logic req, input logic we, input logic io, input logic irw,
      input logic pce, input logic pcs, input logic a, input logic [1:0] b,
      input logic [1:0] op, input logic rw, input logic m2r, input logic ill);
    return {req, we, io, irw, pce, pcs, a, b, op, rw, m2r, ill};
  endfunction

  function automatic logic [13:0] obs_ctrl();
    return pack_ctrl(mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a,
                     alu_src_b, alu_op, reg_write, mem_to_reg, illegal);
  endfunction

  // Control word the specification asks for in each step of an instruction.
  function automatic logic [13:0] exp_ctrl(input state_t s, input logic mr, input logic z);
    case (s)
      ST_FETCH:     return pack_ctrl(1, 0, 0, mr, mr, 0, 0, 2'b01, 2'b00, 0, 0, 0);
      ST_DECODE:    return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0);
      ST_EXEC_R:    return pack_ctrl(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0, 0);
      ST_EXEC_I:    return pack_ctrl(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b11, 0, 0, 0);
      ST_EXEC_ADDR: return pack_ctrl(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0);
      ST_MEM_RD:    return pack_ctrl(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      ST_MEM_WR:    return pack_ctrl(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      ST_WB_ALU:    return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
      ST_WB_MEM:    return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0);
      ST_BRANCH:    return pack_ctrl(0, 0, 0, 0, z, 1, 1, 2'b00, 2'b01, 0, 0, 0);
      ST_ILLEGAL:   return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
      default:      return '0;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] ropc();
    return 7'($urandom);
  endfunction

  function automatic bool_legal(input logic [6:0] o);
    return (o == OPC_R || o == OPC_I || o == OPC_LD || o == OPC_SD || o == OPC_BEQ);
  endfunction

  // Drive one cycle's inputs just after the rising edge, check mid-cycle.
  task automatic step(input state_t es, input logic mr, input logic [6:0] opc, input logic z);
    mem_ready = mr;
    opcode    = opc;
    zero      = z;
    @(negedge clk);
    check($sformatf("%s state", es.name()), 64'(state), 64'(es));
    check($sformatf("%s ctrl", es.name()), 64'(obs_ctrl()), 64'(exp_ctrl(es, mr, z)));
    check($sformatf("%s instret", es.name()), instret, model_instret);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_step();
    reset     = 1'b1;
    mem_ready = rbit();
    opcode    = ropc();
    zero      = rbit();
    @(negedge clk);
    check("rst state", 64'(state), 64'(ST_FETCH));
    check("rst ctrl", 64'(obs_ctrl()), 64'(0));
    check("rst instret", instret, 64'(0));
    @(posedge clk);
    #1;
    model_instret = '0;
  endtask

  // One instruction from fetch to retire, with fw fetch and mw memory waits.
  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input logic z);
    for (int i = 0; i < fw; i++) step(ST_FETCH, 1'b0, ropc(), rbit());
    step(ST_FETCH, 1'b1, ropc(), rbit());
    step(ST_DECODE, rbit(), opc, rbit());
    case (opc)
      OPC_R: begin
        step(ST_EXEC_R, rbit(), opc, rbit());
        step(ST_WB_ALU, rbit(), opc, rbit());
        model_instret++;
      end
      OPC_I: begin
        step(ST_EXEC_I, rbit(), opc, rbit());
        step(ST_WB_ALU, rbit(), opc, rbit());
        model_instret++;
      end
      OPC_LD: begin
        step(ST_EXEC_ADDR, rbit(), opc, rbit());
        for (int i = 0; i < mw; i++) step(ST_MEM_RD, 1'b0, opc, rbit());
        step(ST_MEM_RD, 1'b1, opc, rbit());
        step(ST_WB_MEM, rbit(), opc, rbit());
        model_instret++;
      end
      OPC_SD: begin
        step(ST_EXEC_ADDR, rbit(), opc, rbit());
        for (int i = 0; i < mw; i++) step(ST_MEM_WR, 1'b0, opc, rbit());
        step(ST_MEM_WR, 1'b1, opc, rbit());
        model_instret++;
      end
      OPC_BEQ: begin
        step(ST_BRANCH, rbit(), opc, z);
        model_instret++;
      end
      default: step(ST_ILLEGAL, rbit(), opc, rbit());
    endcase
  endtask

  initial begin
    logic [6:0] opc;
    n_checks      = 0;
    n_errors      = 0;
    model_instret = '0;
    reset         = 1'b1;
    mem_ready     = 1'b1;
    opcode        = '0;
    zero          = 1'b0;

    repeat (3) reset_step();
    reset = 1'b0;

    run_instr(OPC_I, 0, 0, 1'b0);
    check("addi retired", instret, 64'(1));
    run_instr(OPC_LD, 2, 2, 1'b0);
    run_instr(OPC_BEQ, 0, 0, 1'b1);
    run_instr(OPC_BEQ, 0, 0, 1'b0);
    run_instr(7'b1111111, 0, 0, 1'b0);
    run_instr(OPC_R, 1, 0, 1'b0);
    run_instr(OPC_SD, 0, 0, 1'b0);
    check("directed retired", instret, 64'(6));

    // Store abandoned by reset while waiting on memory.
    step(ST_FETCH, 1'b1, ropc(), rbit());
    step(ST_DECODE, rbit(), OPC_SD, rbit());
    step(ST_EXEC_ADDR, rbit(), OPC_SD, rbit());
    step(ST_MEM_WR, 1'b0, OPC_SD, rbit());
    reset_step();
    reset_step();
    reset = 1'b0;

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0: opc = OPC_R;
        1: opc = OPC_I;
        2: opc = OPC_LD;
        3: opc = OPC_SD;
        4: opc = OPC_BEQ;
        default: begin
          opc = ropc();
          while (bool_legal(opc)) opc = ropc();
        end
      endcase
      run_instr(opc, $urandom_range(0, 2), $urandom_range(0, 2), rbit());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
